// File: rtl/chunk_add_pkg.sv
// chunk_add_pkg: shared state type and encodings for the chunked adder sequencer
package chunk_add_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} chunk_add_state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_adder_slice.sv
// ripple_adder_slice: DATA_WIDTH-bit ripple-carry adder chained from full_adder cells
module ripple_adder_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);
  logic [DATA_WIDTH:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(w_c[i]), .sum(sum[i]), .cout(w_c[i+1]));
  end
  assign cout = w_c[DATA_WIDTH];
endmodule

// File: rtl/chunk_add_sequencer.sv
// chunk_add_sequencer: wide adder time-sharing one slice over chunks, LSB first; CHUNK_ADD_SUB_EN adds a sub port for a - b
module chunk_add_sequencer
  import chunk_add_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             din_valid,
  output logic                             din_ready,
`ifdef CHUNK_ADD_SUB_EN
  input  logic                             sub,
`endif
  input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] a,
  input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] b,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [DATA_WIDTH*NUM_CHUNKS:0]   sum,
  output logic                             busy
);
  localparam int W  = DATA_WIDTH * NUM_CHUNKS;
  localparam int IW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  chunk_add_state_t r_state, w_next;
  logic [W-1:0] r_a, r_b;
  logic [W:0] r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_busy, r_dout_valid;
  logic [DATA_WIDTH-1:0] w_a_chunk, w_b_chunk, w_slice_sum;
  logic w_cout, w_accept, w_last, w_sub_in, w_inv;
  assign din_ready  = r_state == IDLE;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign sum        = r_sum;
  assign w_accept   = din_valid && din_ready;
  assign w_last     = r_idx == IW'(NUM_CHUNKS - 1);
  assign w_a_chunk  = r_a[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_b_chunk  = r_b[r_idx*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{w_inv}};
`ifdef CHUNK_ADD_SUB_EN
  logic r_sub;
  always_ff @(posedge clk)
    if (!resetn) r_sub <= 1'b0;
    else if (w_accept) r_sub <= sub;
  assign w_sub_in = sub;
  assign w_inv    = r_sub;
`else
  assign w_sub_in = 1'b0;
  assign w_inv    = 1'b0;
`endif
  ripple_adder_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
    .a(w_a_chunk), .b(w_b_chunk), .cin(r_carry), .sum(w_slice_sum), .cout(w_cout)
  );
  always_ff @(posedge clk)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_accept ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) :
                               (dout_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_busy       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_busy       <= w_next != IDLE;
      r_dout_valid <= w_next == DONE;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sum   <= '0;
        r_idx   <= '0;
        r_carry <= w_sub_in;
      end else if (r_state == RUN) begin
        r_sum[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_slice_sum;
        r_carry <= w_cout;
        if (w_last) r_sum[W] <= w_cout;
        else r_idx <= r_idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_chunk_add_sequencer.sv
// tb_chunk_add_sequencer: randomized and directed checks of the chunked adder against an arithmetic model
module tb_chunk_add_sequencer;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int W  = DW * NC;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic din_valid = 1'b0;
  logic dout_ready = 1'b0;
  logic sub = 1'b0;
  logic din_ready, dout_valid, busy;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W:0] sum;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  chunk_add_sequencer #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (
    .clk(clk),
    .resetn(resetn),
    .din_valid(din_valid),
    .din_ready(din_ready),
`ifdef CHUNK_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a),
    .b(b),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .sum(sum),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    return s ? {1'b0, x} + {1'b0, ~y} + 1 : {1'b0, x} + {1'b0, y};
  endfunction
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int stall);
    logic [W:0] exp;
    int n;
    exp = model(x, y, s);
    a = x;
    b = y;
    sub = s;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", din_ready, 1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
    chk("busy_accept", busy, 1);
    chk("valid_early", dout_valid, 0);
    for (int k = 1; k <= NC; k++) begin
      @(posedge clk); #1;
      chk("busy_run", busy, 1);
      chk("ready_run", din_ready, 0);
      chk("valid_timing", dout_valid, k == NC);
    end
    chk("sum", sum, exp);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_sum", sum, exp);
      chk("stall_valid", dout_valid, 1);
      chk("stall_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    chk("idle_ready", din_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", dout_valid, 0);
  endtask
  initial begin
    logic [W-1:0] qa[3];
    logic [W-1:0] qb[3];
    time t_acc[3];
    int n;
    logic s;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", din_ready, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    resetn = 1'b1;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1);
    run_op(32'hDEADBEEF, 32'h01020304, 1'b0, 10);
    // abort at idx=2, then confirm a clean restart
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    sub = 1'b0;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_ready", din_ready, 1);
    resetn = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, 0);
`ifdef CHUNK_ADD_SUB_EN
    run_op(32'd5, 32'd7, 1'b1, 0);
    run_op(32'd7, 32'd5, 1'b1, 2);
`endif
    for (int i = 0; i < 3; i++) begin
      qa[i] = $urandom;
      qb[i] = $urandom;
    end
    dout_ready = 1'b1;
    sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = qa[i];
      b = qb[i];
      din_valid = 1'b1;
      n = 0;
      while (!din_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_accept_wait", din_ready, 1);
      @(posedge clk);
      t_acc[i] = $time;
      #1;
      if (i > 0) chk("b2b_spacing", 64'(t_acc[i] - t_acc[i-1]), 60);
      n = 0;
      while (!dout_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_sum", sum, model(qa[i], qb[i], 1'b0));
    end
    din_valid = 1'b0;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
`ifdef CHUNK_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op($urandom, $urandom, s, int'($urandom_range(0, 3)));
    end
    run_op('0, '0, 1'b0, 0);
    run_op('1, '1, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
